// File: rtl/fifo_rd_ctrl.sv
// ============================================================================
// Module   : fifo_rd_ctrl
// Purpose  : FIFO read controller with a 3-entry prefetch buffer feeding a
//            valid/ready stream, plus a handshake counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [15:0]           rd_count
);

  localparam int c_DEPTH = 3;

  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_buf [c_DEPTH];
  logic [15:0]           r_rd_count;

  logic                  w_pop;
  logic                  w_push;
  logic [2:0]            w_pending;
  logic [1:0]            w_tail;
  logic [1:0]            w_occ_nxt;
  logic [DATA_WIDTH-1:0] w_shift   [c_DEPTH];
  logic [DATA_WIDTH-1:0] w_buf_nxt [c_DEPTH];

  // Reserve a slot for every in-flight read so a returning word always fits;
  // the consumer side is deliberately left out to keep m_ready off this path.
  assign w_pending  = {1'b0, r_occ} + {2'b00, r_inflight};
  assign fifo_rd_en = !fifo_empty && !rst && !flush && (w_pending < 3'(c_DEPTH));

  assign m_valid  = !rst && (r_occ != 2'd0);
  assign m_data   = rst ? '0 : r_buf[0];
  assign rd_count = rst ? '0 : r_rd_count;

  assign w_pop     = m_valid && m_ready;
  assign w_push    = r_inflight;
  assign w_tail    = r_occ - {1'b0, w_pop};
  assign w_occ_nxt = r_occ - {1'b0, w_pop} + {1'b0, w_push};

  assign w_shift[0] = r_buf[1];
  assign w_shift[1] = r_buf[2];
  assign w_shift[2] = r_buf[2];

  // Head sits at entry 0; a pop shifts down and the arriving word lands
  // just past the surviving entries, which keeps order on pop+push.
  always_comb begin
    for (int i = 0; i < c_DEPTH; i++) begin
      w_buf_nxt[i] = w_pop ? w_shift[i] : r_buf[i];
      if (w_push && (w_tail == 2'(i))) begin
        w_buf_nxt[i] = fifo_dout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_rd_count <= 16'd0;
      for (int i = 0; i < c_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_rd_count <= r_rd_count + {15'd0, w_pop};
      if (flush) begin
        r_occ      <= 2'd0;
        r_inflight <= 1'b0;
      end else begin
        r_occ      <= w_occ_nxt;
        r_inflight <= fifo_rd_en;
        for (int i = 0; i < c_DEPTH; i++) begin
          r_buf[i] <= w_buf_nxt[i];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
// ============================================================================
// Module   : tb_fifo_rd_ctrl
// Purpose  : Self-checking bench for fifo_rd_ctrl with a queue-based FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_rd_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout;
  logic          flush;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [15:0]   rd_count;

  always #5 clk = ~clk;

  fifo_rd_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .rd_count   (rd_count)
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] q [$];
  logic [DW-1:0] got [$];
  logic          s_rd_en;
  logic          s_valid;
  logic          s_hs;
  logic [DW-1:0] s_data;
  logic [15:0]   s_count;
  logic [DW-1:0] popped;

  typedef struct {
    logic          rst;
    logic          flush;
    logic          rdy;
    logic          do_load;
    logic [DW-1:0] load;
    logic          e_rd_en;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic [15:0]   e_count;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle, negedge to negedge: sample after inputs settle, let the
  // posedge happen, then present the popped word on fifo_dout.
  task automatic tick();
    fifo_empty = (q.size() == 0);
    #1;
    s_rd_en = fifo_rd_en;
    s_valid = m_valid;
    s_data  = m_data;
    s_count = rd_count;
    s_hs    = m_valid && m_ready;
    chk("rd_en_while_empty", 32'(fifo_rd_en && fifo_empty), 32'd0);
    @(posedge clk);
    if (s_rd_en && (q.size() > 0)) popped = q.pop_front();
    else popped = 8'hEE;
    @(negedge clk);
    fifo_dout = s_rd_en ? popped : 8'hEE;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int pulses;
    int first;
    int last;
    int n;
    int bad;

    //          rst flush rdy ld  load    rd_en val data    count
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 16'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 16'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 8'h11, 16'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 16'd1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 16'd2};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'd3};

    rst        = 1'b1;
    flush      = 1'b0;
    m_ready    = 1'b0;
    fifo_dout  = '0;
    fifo_empty = 1'b1;
    @(negedge clk);

    // Reset, empty-FIFO idle, then the three-word latency/throughput run
    for (int i = 0; i < 11; i++) begin
      rst     = vecs[i].rst;
      flush   = vecs[i].flush;
      m_ready = vecs[i].rdy;
      if (vecs[i].do_load) q.push_back(vecs[i].load);
      tick();
      chk($sformatf("vec%0d rd_en", i), 32'(s_rd_en), 32'(vecs[i].e_rd_en));
      chk($sformatf("vec%0d m_valid", i), 32'(s_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d rd_count", i), 32'(s_count), 32'(vecs[i].e_count));
      if (vecs[i].e_valid) chk($sformatf("vec%0d m_data", i), 32'(s_data), 32'(vecs[i].e_data));
      if (vecs[i].rst) chk($sformatf("vec%0d m_data_rst", i), 32'(s_data), 32'd0);
    end

    // Back-pressure: only three reads may be issued while the consumer stalls
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) q.push_back(8'(8'hA0 + i));
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      pulses += int'(s_rd_en);
      if (k >= 2) begin
        chk("stall m_valid", 32'(s_valid), 32'd1);
        chk("stall m_data", 32'(s_data), 32'hA0);
      end
    end
    chk("stall rd_en pulses", 32'(pulses), 32'd3);
    chk("stall rd_count", 32'(s_count), 32'd3);
    m_ready = 1'b1;
    got.delete();
    first = -1;
    last  = -1;
    for (int k = 0; k < 40 && got.size() < 10; k++) begin
      tick();
      if (s_hs) begin
        got.push_back(s_data);
        if (first < 0) first = k;
        last = k;
      end
    end
    chk("stream count", 32'(got.size()), 32'd10);
    foreach (got[i]) chk($sformatf("stream word%0d", i), 32'(got[i]), 32'(8'hA0 + i));
    chk("stream span", 32'(last - first), 32'd9);
    tick();
    chk("stream rd_count", 32'(s_count), 32'd13);
    chk("stream drained", 32'(s_valid), 32'd0);

    // Flush with occ=2, inflight=1 and a handshake in the flush cycle
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) q.push_back(8'(8'hB0 + i));
    for (int k = 0; k < 3; k++) tick();
    flush   = 1'b1;
    m_ready = 1'b1;
    tick();
    chk("flush rd_en", 32'(s_rd_en), 32'd0);
    chk("flush m_valid", 32'(s_valid), 32'd1);
    chk("flush m_data", 32'(s_data), 32'hB0);
    flush = 1'b0;
    tick();
    chk("post-flush m_valid", 32'(s_valid), 32'd0);
    chk("post-flush rd_count", 32'(s_count), 32'd14);
    got.delete();
    for (int k = 0; k < 12; k++) begin
      tick();
      if (s_hs) got.push_back(s_data);
    end
    chk("flush resume count", 32'(got.size()), 32'd3);
    foreach (got[i]) chk($sformatf("flush resume word%0d", i), 32'(got[i]), 32'(8'hB3 + i));
    chk("flush final rd_count", 32'(s_count), 32'd17);

    // One-cycle reset mid-stream
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) q.push_back(8'(8'hC0 + i));
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    chk("rst rd_en", 32'(s_rd_en), 32'd0);
    chk("rst m_valid", 32'(s_valid), 32'd0);
    chk("rst m_data", 32'(s_data), 32'd0);
    chk("rst rd_count", 32'(s_count), 32'd0);
    rst = 1'b0;
    tick();
    chk("after rst rd_en", 32'(s_rd_en), 32'd1);
    chk("after rst m_valid", 32'(s_valid), 32'd0);
    chk("after rst rd_count", 32'(s_count), 32'd0);
    got.delete();
    for (int k = 0; k < 20; k++) begin
      tick();
      if (s_hs) got.push_back(s_data);
    end
    chk("rst resume count", 32'(got.size()), 32'd4);
    foreach (got[i]) chk($sformatf("rst resume word%0d", i), 32'(got[i]), 32'(8'hC4 + i));
    chk("rst resume rd_count", 32'(s_count), 32'd4);

    // rd_count wrap after 65536 handshakes
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 65536; i++) q.push_back(8'(i));
    n   = 0;
    bad = 0;
    for (int t = 0; t < 70000 && n < 65536; t++) begin
      tick();
      if (n == 65535) chk("rd_count at 0xFFFF", 32'(s_count), 32'h0000FFFF);
      if (s_hs) begin
        if (s_data !== 8'(n)) bad++;
        n++;
      end
    end
    chk("wrap handshakes", 32'(n), 32'd65536);
    chk("wrap data order errors", 32'(bad), 32'd0);
    tick();
    chk("rd_count wrapped", 32'(s_count), 32'd0);
    chk("wrap drained", 32'(s_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
